// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexing scan controller for a 4-digit 7-segment display.
// Each digit slot lasts BLANK_CYCLES + DWELL_CYCLES clocks:
//   BLANK : all digits off (anti-ghosting gap); brightness is sampled on the
//           last BLANK cycle.
//   ON    : the scanned digit is enabled for (brightness + 1) * DWELL_CYCLES/16
//           clocks.
//   DARK  : all digits off for the rest of the dwell (skipped at full
//           brightness).
// Digits are scanned 0,1,2,3. A new value/dots pair is accepted over a
// valid/ready handshake. It is held as pending and copied to the displayed
// ("active") value only at the frame boundary, which is the last cycle of
// digit 3. A transfer that lands exactly on the boundary cycle goes straight
// into the active value.
//
// Parameters
//   DWELL_CYCLES : per-digit dwell after the gap (multiple of 16, >= 16)
//   BLANK_CYCLES : per-digit gap with all digits off (>= 1)
//
// Ports
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   upd_valid   new display value offered
//   upd_ready   controller can accept a value (= no value pending)
//   upd_value   display value; digit 0 = [15:12], digit 3 = [3:0]
//   upd_dots    dot enables; bit i = digit i
//   brightness  0 = dimmest, 15 = full
//   nibble      nibble of the scanned digit, to the hex decoder
//   dot         dot flag of the scanned digit
//   digit_idx   index of the scanned digit
//   dig_en      one-hot digit enable; all zero while blanking or dark
//   frame_tick  high for the single boundary cycle of each frame
// ----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 4000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_dots,
    input  logic [3:0]  brightness,
    output logic [3:0]  nibble,
    output logic        dot,
    output logic [1:0]  digit_idx,
    output logic [3:0]  dig_en,
    output logic        frame_tick
);

    // One position counter spans the whole digit slot, so the slot length is
    // fixed regardless of brightness and the state thresholds fall out of it.
    localparam int PERIOD = BLANK_CYCLES + DWELL_CYCLES;
    localparam int PW     = $clog2(PERIOD);

    localparam logic [PW-1:0] BLANK_LEN    = PW'(BLANK_CYCLES);
    localparam logic [PW-1:0] LAST_BLANK   = PW'(BLANK_CYCLES - 1);
    localparam logic [PW-1:0] DWELL_LEN    = PW'(DWELL_CYCLES);
    localparam logic [PW-1:0] SLICE        = PW'(DWELL_CYCLES / 16);
    localparam logic [PW-1:0] LAST_POS     = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PRE_LAST_POS = PW'(PERIOD - 2);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_ON,
        ST_DARK
    } state_t;

    state_t         state;
    logic [PW-1:0]  pos;          // cycle within the current digit slot
    logic [PW-1:0]  on_len;       // on-window length latched at the sample point
    logic [15:0]    active_value;
    logic [3:0]     active_dots;
    logic           pending;
    logic [15:0]    pend_value;
    logic [3:0]     pend_dots;

    logic           digit_done;
    logic           boundary;
    logic           transfer;
    logic [1:0]     idx_next;
    logic [15:0]    value_next;
    logic [3:0]     dots_next;
    logic           pending_next;
    logic [PW-1:0]  on_end;
    logic [3:0]     nibble_next;
    logic           dot_next;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        digit_done   = (pos == LAST_POS);
        boundary     = digit_done && (digit_idx == 2'd3);
        transfer     = upd_valid && upd_ready;
        idx_next     = digit_done ? digit_idx + 2'd1 : digit_idx;
        on_end       = BLANK_LEN + on_len - PW'(1);
        value_next   = active_value;
        dots_next    = active_dots;
        pending_next = pending;

        if (boundary) begin
            pending_next = 1'b0;
            if (pending) begin
                value_next = pend_value;
                dots_next  = pend_dots;
            end else if (transfer) begin
                // Offer landing on the boundary bypasses the pending stage.
                value_next = upd_value;
                dots_next  = upd_dots;
            end
        end else if (transfer) begin
            pending_next = 1'b1;
        end

        // Nibble/dot are registered from the post-edge index and value so
        // they always line up with digit_idx in the same cycle.
        nibble_next = 4'(value_next >> {~idx_next, 2'b00});
        dot_next    = dots_next[idx_next];
    end

    // NOTE: the pending payload has no reset; it is only ever read while the
    // pending flag (which is reset) says it holds a captured value.
    always_ff @(posedge CLK) begin
        if (transfer && !boundary) begin
            pend_value <= upd_value;
            pend_dots  <= upd_dots;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side here sees the pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_BLANK;
            pos          <= '0;
            on_len       <= '0;
            digit_idx    <= 2'd0;
            active_value <= 16'h0000;
            active_dots  <= 4'b0000;
            pending      <= 1'b0;
            upd_ready    <= 1'b1;
            dig_en       <= 4'b0000;
            nibble       <= 4'h0;
            dot          <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            pos          <= digit_done ? '0 : pos + PW'(1);
            digit_idx    <= idx_next;
            active_value <= value_next;
            active_dots  <= dots_next;
            pending      <= pending_next;
            upd_ready    <= !pending_next;
            nibble       <= nibble_next;
            dot          <= dot_next;
            // Raised one cycle ahead so it is high during the boundary cycle.
            frame_tick   <= (digit_idx == 2'd3) && (pos == PRE_LAST_POS);

            case (state)
                ST_BLANK: begin
                    if (pos == LAST_BLANK) begin
                        on_len <= (PW'(brightness) + PW'(1)) * SLICE;
                        state  <= ST_ON;
                        dig_en <= 4'b0001 << digit_idx;
                    end
                end
                ST_ON: begin
                    if (pos == on_end) begin
                        dig_en <= 4'b0000;
                        state  <= (on_len == DWELL_LEN) ? ST_BLANK : ST_DARK;
                    end
                end
                ST_DARK: begin
                    if (digit_done) begin
                        state <= ST_BLANK;
                    end
                end
                default: begin
                    state  <= ST_BLANK;
                    dig_en <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Scoreboard bench for seg_scan_ctrl with DWELL_CYCLES = 32, BLANK_CYCLES = 4.
// The reference model tracks the time t since reset release and derives every
// output from plain arithmetic on t: digit = (t / PERIOD) % 4, position
// p = t % PERIOD, and the digit is lit while BLANK <= p < BLANK + on_len.
// After each clock edge the model pushes the expected outputs into a queue.
// A monitor pops an entry on every falling edge and compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DWELL  = 32;
    localparam int BLANK  = 4;
    localparam int PERIOD = BLANK + DWELL;
    localparam int FRAME  = 4 * PERIOD;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_value = 16'h0000;
    logic [3:0]  upd_dots = 4'b0000;
    logic [3:0]  brightness = 4'd15;
    logic [3:0]  nibble;
    logic        dot;
    logic [1:0]  digit_idx;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_value  (upd_value),
        .upd_dots   (upd_dots),
        .brightness (brightness),
        .nibble     (nibble),
        .dot        (dot),
        .digit_idx  (digit_idx),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_t = 0;
    int          m_on_len = 0;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dots = 4'b0000;
    bit          m_pend = 1'b0;
    logic [15:0] m_pval = 16'h0000;
    logic [3:0]  m_pdots = 4'b0000;
    bit          m_xfer;
    bit          m_boundary;

    typedef struct {
        int          t;
        logic [12:0] outs;   // {upd_ready, nibble, dot, digit_idx, dig_en, frame_tick}
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [12:0] expected_outputs();
        int         p = m_t % PERIOD;
        int         d = (m_t / PERIOD) % 4;
        logic [3:0] en;
        logic [3:0] nib;
        logic       tick;
        en   = (p >= BLANK && p < BLANK + m_on_len) ? 4'(1 << d) : 4'b0000;
        nib  = 4'((m_val >> (12 - 4 * d)) & 16'h000F);
        tick = ((m_t % FRAME) == FRAME - 1);
        return {!m_pend, nib, m_dots[d], 2'(d), en, tick};
    endfunction

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_t      = 0;
                m_on_len = 0;
                m_val    = 16'h0000;
                m_dots   = 4'b0000;
                m_pend   = 1'b0;
                sb_q.delete();
            end else begin
                m_xfer     = upd_valid && !m_pend;
                m_boundary = ((m_t % FRAME) == FRAME - 1);
                if ((m_t % PERIOD) == BLANK - 1)
                    m_on_len = (int'(brightness) + 1) * (DWELL / 16);
                if (m_boundary) begin
                    if (m_pend) begin
                        m_val  = m_pval;
                        m_dots = m_pdots;
                        m_pend = 1'b0;
                    end else if (m_xfer) begin
                        m_val  = upd_value;
                        m_dots = upd_dots;
                    end
                end else if (m_xfer) begin
                    m_pval  = upd_value;
                    m_pdots = upd_dots;
                    m_pend  = 1'b1;
                end
                m_t++;
                sb_q.push_back('{t: m_t, outs: expected_outputs()});
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("outputs t=%0d {rdy,nib,dot,idx,en,tick}", e.t),
                      {19'd0, upd_ready, nibble, dot, digit_idx, dig_en, frame_tick},
                      {19'd0, e.outs});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Advance until the model's current cycle is digit d, position pmin..pmax.
    task automatic wait_pos(input int d, input int pmin, input int pmax,
                            input string name);
        int  budget = 2 * FRAME;
        bit  found = 0;
        while (!found && budget > 0) begin
            if (((m_t / PERIOD) % 4 == d) && (m_t % PERIOD >= pmin) &&
                (m_t % PERIOD <= pmax))
                found = 1;
            else begin
                step();
                budget--;
            end
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait %s: position digit %0d p %0d..%0d not reached",
                     name, d, pmin, pmax);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " dig_en"},     dig_en,     0);
        check({tag, " upd_ready"},  upd_ready,  1);
        check({tag, " digit_idx"},  digit_idx,  0);
        check({tag, " nibble"},     nibble,     0);
        check({tag, " dot"},        dot,        0);
        check({tag, " frame_tick"}, frame_tick, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge CLK);
        #2;
        check_reset_state("reset");
        RST_N = 1'b1;

        // Full brightness, no update: two frames of blank/on at digit rate.
        run(2 * FRAME);

        // Brightness 3, then drop to 0 while digit 1 is lit.
        brightness = 4'd3;
        run(FRAME);
        wait_pos(1, BLANK + 2, BLANK + 2, "dim mid-on");
        brightness = 4'd0;
        run(2 * PERIOD);
        brightness = 4'd3;
        run(FRAME);

        // Mid-frame update, then a second offer while pending.
        wait_pos(1, 10, 10, "update offer");
        upd_valid = 1'b1;
        upd_value = 16'h1A2F;
        upd_dots  = 4'b0101;
        step();
        upd_valid = 1'b0;
        run(3);
        upd_valid = 1'b1;
        upd_value = 16'h5555;
        upd_dots  = 4'b1111;
        run(10);
        upd_valid = 1'b0;
        run(2 * FRAME);

        // Offer exactly on the boundary cycle: bypass into the new frame.
        wait_pos(3, PERIOD - 1, PERIOD - 1, "boundary offer");
        upd_valid = 1'b1;
        upd_value = 16'hBEEF;
        upd_dots  = 4'b1000;
        step();
        upd_valid = 1'b0;
        run(FRAME);

        // Reset during digit 2 ON with a value pending.
        brightness = 4'd15;
        wait_pos(0, 10, 10, "pending before reset");
        upd_valid = 1'b1;
        upd_value = 16'h1234;
        upd_dots  = 4'b0011;
        step();
        upd_valid = 1'b0;
        wait_pos(2, BLANK + 6, BLANK + 20, "digit 2 on");
        #1;
        RST_N = 1'b0;
        #1;
        check_reset_state("mid-frame reset");
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        run(FRAME + PERIOD);

        // Randomised brightness and update traffic.
        repeat (6 * FRAME) begin
            step();
            if ($urandom_range(0, 40) == 0)
                brightness = 4'($urandom);
            upd_valid = ($urandom_range(0, 99) < 3);
            upd_value = 16'($urandom);
            upd_dots  = 4'($urandom);
        end
        upd_valid = 1'b0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
